// File: rtl/grader.sv
// Responder side of the number-baseball handshake: holds a 4-digit BCD secret and
// grades one question per request, one digit per cycle, reporting strike/ball/count.
//
//   state | meaning
//   IDLE  | waiting for ask_valid
//   CMP   | comparing question digit idx (0 = leftmost) against the secret
//   RESP  | reply_valid pulse cycle; decides whether the game is over
//   DONE  | solved or gave up; holds until reset or secret_load
module grader #(
    parameter logic [15:0] INIT_SECRET = 16'h0123,
    parameter logic [15:0] MAX_ASKS    = 16'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] secret_in,
    input  logic        secret_load,
    input  logic [15:0] question,
    input  logic        ask_valid,
    input  logic        ask_ready,
    output logic        reply_ready,
    output logic        reply_valid,
    output logic [2:0]  strike,
    output logic [2:0]  ball,
    output logic        correct,
    output logic [15:0] cnt,
    output logic        invalid,
    output logic        solved,
    output logic        gave_up
);

    typedef enum logic [1:0] {IDLE, CMP, RESP, DONE} state_t;

    state_t      state;
    logic [1:0]  idx;
    logic [15:0] secret;
    logic [15:0] q_reg;
    logic [2:0]  strike_acc;
    logic [2:0]  ball_acc;

    logic [3:0]  q_dig;
    logic        strike_hit;
    logic        ball_hit;
    logic [2:0]  strike_next;
    logic [2:0]  ball_next;
    logic        invalid_q;
    logic [15:0] cnt_next;

    // The solver's ask_ready is informational; the grader never waits on it.
    logic ask_ready_unused;
    assign ask_ready_unused = ask_ready;

    function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] i);
        case (i)
            2'd0:    return v[15:12];
            2'd1:    return v[11:8];
            2'd2:    return v[7:4];
            default: return v[3:0];
        endcase
    endfunction

    always_comb begin
        q_dig      = nib(q_reg, idx);
        strike_hit = (q_dig == nib(secret, idx));
        ball_hit   = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if ((2'(j) != idx) && (nib(secret, 2'(j)) == q_dig))
                ball_hit = 1'b1;
        end
        strike_next = strike_acc + {2'b00, strike_hit};
        ball_next   = ball_acc + {2'b00, ball_hit & ~strike_hit};
    end

    always_comb begin
        invalid_q = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (nib(q_reg, 2'(i)) > 4'd9)
                invalid_q = 1'b1;
            for (int j = i + 1; j < 4; j++) begin
                if (nib(q_reg, 2'(i)) == nib(q_reg, 2'(j)))
                    invalid_q = 1'b1;
            end
        end
        cnt_next = (&cnt) ? cnt : cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 2'd0;
            secret      <= INIT_SECRET;
            q_reg       <= 16'h0000;
            strike_acc  <= 3'd0;
            ball_acc    <= 3'd0;
            reply_ready <= 1'b0;
            reply_valid <= 1'b0;
            strike      <= 3'd0;
            ball        <= 3'd0;
            correct     <= 1'b0;
            cnt         <= 16'h0000;
            invalid     <= 1'b0;
            solved      <= 1'b0;
            gave_up     <= 1'b0;
        end else if (secret_load) begin
            // Drops any in-flight question without a reply and restarts the game.
            state       <= IDLE;
            idx         <= 2'd0;
            secret      <= secret_in;
            strike_acc  <= 3'd0;
            ball_acc    <= 3'd0;
            reply_ready <= 1'b0;
            reply_valid <= 1'b0;
            strike      <= 3'd0;
            ball        <= 3'd0;
            correct     <= 1'b0;
            cnt         <= 16'h0000;
            invalid     <= 1'b0;
            solved      <= 1'b0;
            gave_up     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ask_valid) begin
                        q_reg       <= question;
                        reply_ready <= 1'b1;
                        strike_acc  <= 3'd0;
                        ball_acc    <= 3'd0;
                        idx         <= 2'd0;
                        state       <= CMP;
                    end
                end
                CMP: begin
                    strike_acc <= strike_next;
                    ball_acc   <= ball_next;
                    idx        <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        strike      <= strike_next;
                        ball        <= ball_next;
                        correct     <= (strike_next == 3'd4);
                        invalid     <= invalid_q;
                        cnt         <= cnt_next;
                        reply_valid <= 1'b1;
                        reply_ready <= 1'b0;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    reply_valid <= 1'b0;
                    if (correct || (cnt == MAX_ASKS)) begin
                        solved  <= correct;
                        gave_up <= ~correct;
                        state   <= DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_grader.sv
// Bench for grader: a digit-level reference model feeds a reply scoreboard that a
// monitor drains on every reply_valid; a second instance covers the give-up limit.
module tb_grader;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] secret_in, question;
    logic        secret_load, ask_valid, ask_ready;
    logic        reply_ready, reply_valid, correct, invalid, solved, gave_up;
    logic [2:0]  strike, ball;
    logic [15:0] cnt;

    logic [15:0] secret_in_6, question_6;
    logic        secret_load_6, ask_valid_6;
    logic        reply_ready_6, reply_valid_6, correct_6, invalid_6, solved_6, gave_up_6;
    logic [2:0]  strike_6, ball_6;
    logic [15:0] cnt_6;

    always #5 clk = ~clk;

    grader dut (
        .clk(clk), .reset(reset), .secret_in(secret_in), .secret_load(secret_load),
        .question(question), .ask_valid(ask_valid), .ask_ready(ask_ready),
        .reply_ready(reply_ready), .reply_valid(reply_valid), .strike(strike), .ball(ball),
        .correct(correct), .cnt(cnt), .invalid(invalid), .solved(solved), .gave_up(gave_up)
    );

    grader #(.MAX_ASKS(16'd3)) dut6 (
        .clk(clk), .reset(reset), .secret_in(secret_in_6), .secret_load(secret_load_6),
        .question(question_6), .ask_valid(ask_valid_6), .ask_ready(ask_ready),
        .reply_ready(reply_ready_6), .reply_valid(reply_valid_6), .strike(strike_6), .ball(ball_6),
        .correct(correct_6), .cnt(cnt_6), .invalid(invalid_6), .solved(solved_6), .gave_up(gave_up_6)
    );

    typedef struct {
        logic [2:0]  s;
        logic [2:0]  b;
        logic        c;
        logic        inv;
        logic [15:0] n;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_secret;
    logic [15:0] m_cnt;
    bit          m_done;
    localparam logic [15:0] MAX_MAIN = 16'd1024;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Game rules, digit by digit: leftmost digit is position 0.
    function automatic exp_t grade(input logic [15:0] s, input logic [15:0] q);
        exp_t e;
        int st = 0, bl = 0;
        bit inv = 0;
        int qd[4], sd[4];
        for (int i = 0; i < 4; i++) begin
            qd[i] = int'(q[15-4*i -: 4]);
            sd[i] = int'(s[15-4*i -: 4]);
        end
        for (int i = 0; i < 4; i++) begin
            if (qd[i] == sd[i]) st++;
            else begin
                bit found = 0;
                for (int j = 0; j < 4; j++) if (j != i && sd[j] == qd[i]) found = 1;
                if (found) bl++;
            end
            if (qd[i] > 9) inv = 1;
            for (int j = i + 1; j < 4; j++) if (qd[i] == qd[j]) inv = 1;
        end
        e.s = 3'(st); e.b = 3'(bl); e.c = (st == 4); e.inv = inv; e.n = 16'h0;
        return e;
    endfunction

    function automatic logic [15:0] rand_distinct();
        int d[4];
        for (int i = 0; i < 4; i++) begin
            bit dup;
            do begin
                d[i] = int'($urandom_range(0, 9));
                dup = 0;
                for (int j = 0; j < i; j++) if (d[j] == d[i]) dup = 1;
            end while (dup);
        end
        return {4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
    endfunction

    always @(negedge clk) begin
        if (reply_valid && reply_ready)
            chk("ready_valid_overlap", 32'(reply_ready), 32'd0);
        if (reply_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_reply", 32'(reply_valid), 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("strike", 32'(strike), 32'(e.s));
                chk("ball", 32'(ball), 32'(e.b));
                chk("correct", 32'(correct), 32'(e.c));
                chk("invalid", 32'(invalid), 32'(e.inv));
                chk("cnt", 32'(cnt), 32'(e.n));
            end
        end
    end

    task automatic load(input logic [15:0] v);
        @(negedge clk);
        secret_load = 1'b1;
        secret_in   = v;
        @(negedge clk);
        secret_load = 1'b0;
        m_secret = v; m_cnt = 16'h0; m_done = 0;
        chk("load_clears", {cnt, strike, ball, correct, invalid, solved, gave_up, reply_ready, reply_valid}, 32'd0);
    endtask

    task automatic do_ask(input logic [15:0] q);
        exp_t e;
        int rdy = 0, n = 0;
        e = grade(m_secret, q);
        m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        e.n = m_cnt;
        sbq.push_back(e);
        @(negedge clk);
        ask_valid = 1'b1;
        question  = q;
        @(negedge clk);
        ask_valid = 1'b0;
        question  = 16'($urandom);
        while (!reply_valid && n < 20) begin
            if (reply_ready) rdy++;
            n++;
            @(negedge clk);
        end
        chk("ready_cycles", 32'(rdy), 32'd4);
        m_done = e.c || (m_cnt == MAX_MAIN);
        @(negedge clk);
        chk("solved", 32'(solved), 32'(m_done && e.c));
        chk("gave_up", 32'(gave_up), 32'(m_done && !e.c));
    endtask

    task automatic ask_ignored(input logic [15:0] q);
        @(negedge clk);
        ask_valid = 1'b1;
        question  = q;
        repeat (4) begin
            @(negedge clk);
            chk("ignored_no_ready", 32'(reply_ready), 32'd0);
        end
        ask_valid = 1'b0;
    endtask

    task automatic ask6(input logic [15:0] q, input logic [15:0] exp_cnt);
        int n = 0;
        @(negedge clk);
        ask_valid_6 = 1'b1;
        question_6  = q;
        @(negedge clk);
        ask_valid_6 = 1'b0;
        while (!reply_valid_6 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("t6_reply_seen", 32'(reply_valid_6), 32'd1);
        chk("t6_cnt", 32'(cnt_6), 32'(exp_cnt));
        chk("t6_strike_ball", {strike_6, ball_6}, 32'd0);
        @(negedge clk);
        chk("t6_gave_up", 32'(gave_up_6), 32'(exp_cnt == 16'd3));
    endtask

    initial begin
        reset = 1'b1; secret_in = 16'h0; secret_load = 1'b0; question = 16'h0;
        ask_valid = 1'b0; ask_ready = 1'b1;
        secret_in_6 = 16'h0; secret_load_6 = 1'b0; question_6 = 16'h0; ask_valid_6 = 1'b0;
        m_secret = 16'h0123; m_cnt = 16'h0; m_done = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {cnt, strike, ball, correct, invalid, solved, gave_up, reply_ready, reply_valid}, 32'd0);
        reset = 1'b0;

        // T1: idle after reset
        repeat (5) begin
            @(negedge clk);
            chk("idle_outputs", {cnt, strike, ball, correct, invalid, solved, gave_up, reply_ready, reply_valid}, 32'd0);
        end

        // Reset secret is 0123
        do_ask(16'h0123);
        load(16'h1234);

        // T2
        do_ask(16'h0123);
        chk("t2_ball3", {strike, ball, correct}, {25'd0, 3'd0, 3'd3, 1'b0});

        // T3
        load(16'h5678);
        do_ask(16'h5687);
        do_ask(16'h5678);
        chk("t3_solved", {solved, cnt}, {15'd0, 1'b1, 16'd2});
        ask_ignored(16'h1234);

        // T4
        load(16'h1234);
        do_ask(16'h1123);
        do_ask(16'h12A4);
        chk("t4_invalid_cnt", {invalid, cnt}, {15'd0, 1'b1, 16'd2});

        // T5: secret_load lands during the second CMP cycle
        @(negedge clk);
        ask_valid = 1'b1;
        question  = 16'h1243;
        @(negedge clk);
        ask_valid = 1'b0;
        @(negedge clk);
        secret_load = 1'b1;
        secret_in   = 16'h9876;
        @(negedge clk);
        secret_load = 1'b0;
        m_secret = 16'h9876; m_cnt = 16'h0; m_done = 0;
        begin
            int rv = 0;
            repeat (6) begin
                if (reply_valid || reply_ready) rv++;
                @(negedge clk);
            end
            chk("t5_no_reply", 32'(rv), 32'd0);
        end
        chk("t5_cnt", 32'(cnt), 32'd0);
        do_ask(16'h9867);

        // Randomised games
        for (int g = 0; g < 8; g++) begin
            load(rand_distinct());
            for (int k = 0; k < 10 && !m_done; k++) begin
                int pick = int'($urandom_range(0, 7));
                logic [15:0] q;
                if (pick == 0)      q = m_secret;
                else if (pick <= 2) q = 16'($urandom);
                else                q = rand_distinct();
                do_ask(q);
            end
            if (m_done) ask_ignored(rand_distinct());
        end

        // T6: give-up limit on the MAX_ASKS=3 instance
        @(negedge clk);
        secret_load_6 = 1'b1;
        secret_in_6   = 16'h1234;
        @(negedge clk);
        secret_load_6 = 1'b0;
        ask6(16'h5678, 16'd1);
        ask6(16'h5678, 16'd2);
        ask6(16'h5678, 16'd3);
        chk("t6_not_solved", 32'(solved_6), 32'd0);
        @(negedge clk);
        ask_valid_6 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("t6_ignored", {reply_ready_6, reply_valid_6}, 32'd0);
        end
        ask_valid_6 = 1'b0;

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
